// File: rtl/tap_config_loader.sv
// Writer side of the NLFSR tap-selection interface: gathers tap indices into a shadow
// buffer and publishes them atomically on co_buf, holding the NLFSR in reset while reloading.
module tap_config_loader #(
    parameter int NUM_OF_TAPS = 15,
    parameter int REG_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OF_TAPS*8-1:0] co_buf,
    output logic                     nlfsr_res,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     cfg_err
);
    localparam int CW = $clog2(NUM_OF_TAPS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_OF_TAPS - 1);
    localparam logic [8:0] REG_LIM = 9'(REG_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [NUM_OF_TAPS*8-1:0] shadow_q, shadow_d;
    logic [NUM_OF_TAPS*8-1:0] co_buf_q, co_buf_d;
    logic                     err_q, err_d;
    logic                     nres_q, nres_d;
    logic                     done_q, done_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     bad_idx;

    assign bad_idx = {1'b0, in_data} >= REG_LIM;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shadow_q  <= '0;
            co_buf_q  <= '0;
            err_q     <= 1'b0;
            nres_q    <= 1'b1;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            co_buf_q  <= co_buf_d;
            err_q     <= err_d;
            nres_q    <= nres_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shadow_d  = shadow_q;
        co_buf_d  = co_buf_q;
        err_d     = err_q;
        nres_d    = nres_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    count_d   = '0;
                    shadow_d  = '0;
                    err_d     = 1'b0;
                    cfg_err_d = 1'b0;
                    nres_d    = 1'b1;
                end
            end
            LOAD: begin
                // abort beats a coincident handshake; the byte is dropped
                if (abort) begin
                    state_d  = IDLE;
                    count_d  = '0;
                    shadow_d = '0;
                end else if (in_valid) begin
                    for (int i = 0; i < NUM_OF_TAPS; i++) begin
                        if (count_q == CW'(NUM_OF_TAPS - 1 - i)) begin
                            shadow_d[i*8 +: 8] = in_data;
                        end
                    end
                    count_d = count_q + 1'b1;
                    err_d   = err_q | bad_idx;
                    if (count_q == LAST_COUNT) begin
                        if (err_q || bad_idx) begin
                            state_d   = IDLE;
                            cfg_err_d = 1'b1;
                        end else begin
                            state_d = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
                state_d  = IDLE;
                co_buf_d = shadow_q;
                done_d   = 1'b1;
                nres_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign co_buf    = co_buf_q;
    assign nlfsr_res = nres_q;
    assign cfg_done  = done_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_tap_config_loader.sv
// Randomized bench for tap_config_loader against a queue-based model of the load protocol.
module tb_tap_config_loader;
    logic         clk, res, start, abort, in_valid;
    logic [7:0]   in_data;
    logic         in_ready, nlfsr_res, busy, cfg_done, cfg_err;
    logic [119:0] co_buf;

    tap_config_loader #(.NUM_OF_TAPS(15), .REG_WIDTH(16)) dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .co_buf(co_buf), .nlfsr_res(nlfsr_res), .busy(busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cycles = 0;
    int done_pulses = 0;

    // model: a load is a list of received bytes; commit happens one cycle after the 15th
    logic [119:0]  m_co;
    bit            m_load, m_commit, m_done, m_nres, m_err;
    byte unsigned  m_q[$];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_co = '0; m_load = 0; m_commit = 0; m_done = 0; m_nres = 1; m_err = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit vld, input logic [7:0] d);
        bit any_bad;
        m_done = 0;
        if (m_commit) begin
            for (int k = 0; k < 15; k++) m_co[(14-k)*8 +: 8] = m_q[k];
            m_done = 1; m_nres = 0; m_commit = 0;
        end else if (!m_load) begin
            if (st) begin
                m_load = 1; m_q.delete(); m_err = 0; m_nres = 1;
            end
        end else if (ab) begin
            m_load = 0;
        end else if (vld) begin
            m_q.push_back(d);
            if (m_q.size() == 15) begin
                m_load = 0;
                any_bad = 0;
                foreach (m_q[k]) if (m_q[k] >= 16) any_bad = 1;
                if (any_bad) m_err = 1;
                else m_commit = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("co_buf", co_buf, m_co);
        chk("nlfsr_res", nlfsr_res, m_nres);
        chk("cfg_done", cfg_done, m_done);
        chk("cfg_err", cfg_err, m_err);
        chk("in_ready", in_ready, m_load);
        chk("busy", busy, m_load | m_commit);
    endtask

    task automatic step(input bit st, input bit ab, input bit vld, input logic [7:0] d);
        start = st; abort = ab; in_valid = vld; in_data = d;
        @(posedge clk);
        model_edge(st, ab, vld, d);
        #1;
        check_all();
        if (busy) busy_cycles++;
        if (cfg_done) done_pulses++;
        start = 0; abort = 0; in_valid = 0; in_data = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input int max_gap);
        int g;
        g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        for (int i = 0; i < g; i++) step(0, 0, 0, 8'($urandom));
        step(0, 0, 1, d);
    endtask

    task automatic load(input logic [7:0] b [15], input int max_gap);
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 15; i++) send(b[i], max_gap);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
    endtask

    logic [7:0]   bytes [15];
    logic [119:0] exp_c, saved;

    initial begin
        res = 1'b1; start = 0; abort = 0; in_valid = 0; in_data = 8'h00;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #2 res = 1'b0;

        // clean load 0x0F..0x01
        for (int i = 0; i < 15; i++) bytes[i] = 8'(15 - i);
        for (int i = 1; i <= 15; i++) exp_c[i*8-1 -: 8] = 8'(i);
        busy_cycles = 0; done_pulses = 0;
        load(bytes, 0);
        chk("clean_const", co_buf, exp_c);
        chk("clean_busy_len", busy_cycles, 16);
        chk("clean_done_cnt", done_pulses, 1);
        chk("clean_nres", nlfsr_res, 0);

        // same load with random in_valid gaps
        done_pulses = 0;
        load(bytes, 3);
        chk("gap_const", co_buf, exp_c);
        chk("gap_done_cnt", done_pulses, 1);

        // bad index in byte 5 after a good commit
        for (int i = 0; i < 15; i++) bytes[i] = 8'($urandom_range(0, 15));
        load(bytes, 1);
        saved = m_co;
        bytes[4] = 8'h10;
        done_pulses = 0;
        load(bytes, 1);
        chk("bad_err", cfg_err, 1);
        chk("bad_keep", co_buf, saved);
        chk("bad_nres", nlfsr_res, 1);
        chk("bad_no_done", done_pulses, 0);
        for (int i = 0; i < 15; i++) bytes[i] = 8'($urandom_range(0, 15));
        step(1, 0, 0, 8'h00);
        chk("err_clr_start", cfg_err, 0);
        for (int i = 0; i < 15; i++) send(bytes[i], 0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // abort after 7 bytes, coinciding with a handshake
        saved = m_co;
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 15)), 1);
        step(0, 1, 1, 8'h03);
        chk("abort_keep", co_buf, saved);
        chk("abort_nres", nlfsr_res, 1);
        chk("abort_idle", busy, 0);
        for (int i = 0; i < 15; i++) bytes[i] = 8'($urandom_range(0, 15));
        load(bytes, 0);
        chk("post_abort_top", co_buf[119:112], bytes[0]);
        chk("post_abort_bot", co_buf[7:0], bytes[14]);

        // start pulse during load is ignored
        for (int i = 0; i < 15; i++) bytes[i] = 8'($urandom_range(0, 15));
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) send(bytes[i], 0);
        step(1, 0, 0, 8'h00);
        for (int i = 3; i < 15; i++) send(bytes[i], 0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("mid_start_top", co_buf[119:112], bytes[0]);

        // asynchronous reset after 10 bytes
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 15)), 0);
        res = 1'b1;
        #1;
        chk("arst_co", co_buf, 120'h0);
        chk("arst_nres", nlfsr_res, 1);
        chk("arst_rdy", in_ready, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #2 res = 1'b0;
        step(0, 0, 0, 8'h00);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 19) == 0) ? 8'($urandom_range(16, 255))
                                              : 8'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
